// File: rtl/pcie_tx_pkg.sv
// Shared types, constants and the data-credit cost helper for the TX TLP arbiter.
package pcie_tx_pkg;

   localparam int PKG_HDR_CRED_W  = 8;
   localparam int PKG_DATA_CRED_W = 12;
   localparam int PKG_N_REQ       = 3;

   // Requester index doubles as its flow-control class
   typedef enum logic [1:0] {
      FC_P   = 2'd0,
      FC_NP  = 2'd1,
      FC_CPL = 2'd2
   } fc_class_e;

   // fmt[1] set means the TLP carries a data payload, fmt[0] selects 4DW header
   localparam int FMT_DATA_BIT = 1;
   localparam int FMT_4DW_BIT  = 0;

   // Arbiter states
   localparam logic [0:0] ST_IDLE = 1'b0;
   localparam logic [0:0] ST_SEND = 1'b1;

   // Data credits are 4 DW each; length 0 with data encodes 1024 DW
   function automatic logic [PKG_DATA_CRED_W-1:0] data_cost(input logic [2:0] fmt,
                                                             input logic [9:0] len);
      logic [PKG_DATA_CRED_W-1:0] c;
      if (!fmt[FMT_DATA_BIT])
         c = '0;
      else if (len == 10'd0)
         c = PKG_DATA_CRED_W'(256);
      else
         c = ({2'b00, len} + 12'd3) >> 2;
      return c;
   endfunction

endpackage

// File: rtl/pcie_tx_tlp_arbiter_if.sv
// Request, flow-control and TLP output bundle between sources, DLLP path and the TX layer.
interface pcie_tx_tlp_arbiter_if
   import pcie_tx_pkg::*;
#(
   parameter int N_REQ       = PKG_N_REQ,
   parameter int HDR_CRED_W  = PKG_HDR_CRED_W,
   parameter int DATA_CRED_W = PKG_DATA_CRED_W
);
   logic [N_REQ-1:0]        req_valid_i;
   logic [N_REQ-1:0]        req_ready_o;
   logic [N_REQ*128-1:0]    req_payload_i;
   logic [N_REQ*32-1:0]     req_addr_i;
   logic [N_REQ*3-1:0]      req_fmt_i;
   logic [N_REQ*5-1:0]      req_type_i;
   logic [N_REQ*3-1:0]      req_tc_i;
   logic [N_REQ*16-1:0]     req_requestID_i;
   logic [N_REQ*16-1:0]     req_completID_i;
   logic [N_REQ*10-1:0]     req_length_i;

   logic                    fc_valid_i;
   logic [1:0]              fc_class_i;
   logic [HDR_CRED_W-1:0]   fc_hdr_limit_i;
   logic [DATA_CRED_W-1:0]  fc_data_limit_i;
   logic                    fc_init_done_o;

   logic [127:0]            payload_o;
   logic [31:0]             addr_o;
   logic [2:0]              header_fmt_o;
   logic [4:0]              header_type_o;
   logic [2:0]              header_tc_o;
   logic [15:0]             header_requestID_o;
   logic [15:0]             header_completID_o;
   logic [9:0]              header_length_o;
   logic                    tlp_valid_o;
   logic                    tlp_ready_i;

   // Arbiter side
   modport slave (
      input  req_valid_i, req_payload_i, req_addr_i, req_fmt_i, req_type_i, req_tc_i,
             req_requestID_i, req_completID_i, req_length_i,
             fc_valid_i, fc_class_i, fc_hdr_limit_i, fc_data_limit_i, tlp_ready_i,
      output req_ready_o, fc_init_done_o, payload_o, addr_o, header_fmt_o, header_type_o,
             header_tc_o, header_requestID_o, header_completID_o, header_length_o, tlp_valid_o
   );

   // Requesters, DLLP credit path and TX transaction layer side
   modport master (
      output req_valid_i, req_payload_i, req_addr_i, req_fmt_i, req_type_i, req_tc_i,
             req_requestID_i, req_completID_i, req_length_i,
             fc_valid_i, fc_class_i, fc_hdr_limit_i, fc_data_limit_i, tlp_ready_i,
      input  req_ready_o, fc_init_done_o, payload_o, addr_o, header_fmt_o, header_type_o,
             header_tc_o, header_requestID_o, header_completID_o, header_length_o, tlp_valid_o
   );
endinterface

// File: rtl/pcie_fc_credit_gate.sv
// Per-class flow-control credit tracker: limit/consumed counters, init flag, has-credit check.
module pcie_fc_credit_gate #(
   parameter int HDR_CRED_W  = 8,
   parameter int DATA_CRED_W = 12
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   i_load,
   input  logic [HDR_CRED_W-1:0]  i_hdr_limit,
   input  logic [DATA_CRED_W-1:0] i_data_limit,
   input  logic                   i_consume,
   input  logic [DATA_CRED_W-1:0] i_data_cost,
   output logic                   o_has_credit,
   output logic                   o_init
);
   logic [HDR_CRED_W-1:0]  r_hdr_limit;
   logic [HDR_CRED_W-1:0]  r_hdr_cons;
   logic [DATA_CRED_W-1:0] r_data_limit;
   logic [DATA_CRED_W-1:0] r_data_cons;
   logic                   r_init;
   logic [HDR_CRED_W-1:0]  w_hdr_gap;
   logic [DATA_CRED_W-1:0] w_data_gap;

   // Limits come from the link partner; the first update arms the class
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_hdr_limit  <= '0;
         r_data_limit <= '0;
         r_init       <= 1'b0;
      end else if (i_load) begin
         r_hdr_limit  <= i_hdr_limit;
         r_data_limit <= i_data_limit;
         r_init       <= 1'b1;
      end
   end

   // Consumed counters advance on each grant, independent of a same-cycle limit load
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_hdr_cons  <= '0;
         r_data_cons <= '0;
      end else if (i_consume) begin
         r_hdr_cons  <= r_hdr_cons + HDR_CRED_W'(1);
         r_data_cons <= r_data_cons + i_data_cost;
      end
   end

   // Modular gaps: a wrapped limit ahead of the consumed count is still valid credit
   assign w_hdr_gap    = r_hdr_limit - r_hdr_cons;
   assign w_data_gap   = r_data_limit - r_data_cons;
   assign o_has_credit = r_init && (w_hdr_gap != '0) && (w_data_gap >= i_data_cost);
   assign o_init       = r_init;

endmodule

// File: rtl/pcie_tx_tlp_arbiter.sv
// Round-robin, credit-gated arbiter sharing the TX TLP build port between P, NP and CPL.
module pcie_tx_tlp_arbiter
   import pcie_tx_pkg::*;
#(
   parameter int HDR_CRED_W  = PKG_HDR_CRED_W,
   parameter int DATA_CRED_W = PKG_DATA_CRED_W,
   parameter int N_REQ       = PKG_N_REQ
) (
   input  logic                   clk,
   input  logic                   rst_n,
   pcie_tx_tlp_arbiter_if.slave   bus
);
   logic [N_REQ-1:0]       w_elig;
   logic [N_REQ-1:0]       w_has_credit;
   logic [N_REQ-1:0]       w_init;
   logic [N_REQ-1:0]       w_fc_load;
   logic [N_REQ-1:0]       w_grant;
   logic [DATA_CRED_W-1:0] w_cost [N_REQ];
   logic                   w_gnt_any;
   logic [1:0]             w_gnt_idx;
   logic [2:0]             w_sum;
   logic [1:0]             w_j;

   logic [0:0]             r_state;
   logic [1:0]             r_ptr;
   logic [127:0]           r_payload;
   logic [31:0]            r_addr;
   logic [2:0]             r_fmt;
   logic [4:0]             r_type;
   logic [2:0]             r_tc;
   logic [15:0]            r_rid;
   logic [15:0]            r_cid;
   logic [9:0]             r_len;

   for (genvar i = 0; i < N_REQ; i++) begin : g_class
      localparam fc_class_e CLS = fc_class_e'(i);
      assign w_cost[i]    = DATA_CRED_W'(data_cost(bus.req_fmt_i[i*3 +: 3], bus.req_length_i[i*10 +: 10]));
      assign w_fc_load[i] = bus.fc_valid_i && (bus.fc_class_i == CLS);

      pcie_fc_credit_gate #(
         .HDR_CRED_W  (HDR_CRED_W),
         .DATA_CRED_W (DATA_CRED_W)
      ) u_gate (
         .clk          (clk),
         .rst_n        (rst_n),
         .i_load       (w_fc_load[i]),
         .i_hdr_limit  (bus.fc_hdr_limit_i),
         .i_data_limit (bus.fc_data_limit_i),
         .i_consume    (w_grant[i]),
         .i_data_cost  (w_cost[i]),
         .o_has_credit (w_has_credit[i]),
         .o_init       (w_init[i])
      );
   end

   assign w_elig = bus.req_valid_i & w_has_credit;

   // First eligible requester at or after the pointer, wrapping; only granted in IDLE
   always_comb begin
      w_gnt_any = 1'b0;
      w_gnt_idx = '0;
      w_grant   = '0;
      w_sum     = '0;
      w_j       = '0;
      for (int k = 0; k < N_REQ; k++) begin
         w_sum = {1'b0, r_ptr} + 3'(k);
         w_j   = (w_sum >= 3'(N_REQ)) ? 2'(w_sum - 3'(N_REQ)) : w_sum[1:0];
         if (!w_gnt_any && w_elig[w_j]) begin
            w_gnt_any = 1'b1;
            w_gnt_idx = w_j;
         end
      end
      if (r_state == ST_IDLE && w_gnt_any)
         w_grant[w_gnt_idx] = 1'b1;
   end

   // Grant/send FSM with field capture; the SEND cycle blocks any new grant
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state   <= ST_IDLE;
         r_ptr     <= '0;
         r_payload <= '0;
         r_addr    <= '0;
         r_fmt     <= '0;
         r_type    <= '0;
         r_tc      <= '0;
         r_rid     <= '0;
         r_cid     <= '0;
         r_len     <= '0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (w_gnt_any) begin
                  r_state   <= ST_SEND;
                  r_ptr     <= (w_gnt_idx == 2'(N_REQ-1)) ? 2'd0 : w_gnt_idx + 2'd1;
                  r_payload <= bus.req_payload_i[w_gnt_idx*128 +: 128];
                  r_addr    <= bus.req_addr_i[w_gnt_idx*32 +: 32];
                  r_fmt     <= bus.req_fmt_i[w_gnt_idx*3 +: 3];
                  r_type    <= bus.req_type_i[w_gnt_idx*5 +: 5];
                  r_tc      <= bus.req_tc_i[w_gnt_idx*3 +: 3];
                  r_rid     <= bus.req_requestID_i[w_gnt_idx*16 +: 16];
                  r_cid     <= bus.req_completID_i[w_gnt_idx*16 +: 16];
                  r_len     <= bus.req_length_i[w_gnt_idx*10 +: 10];
               end
            end
            default: begin
               if (bus.tlp_ready_i)
                  r_state <= ST_IDLE;
            end
         endcase
      end
   end

   assign bus.req_ready_o        = w_grant;
   assign bus.tlp_valid_o        = (r_state == ST_SEND);
   assign bus.fc_init_done_o     = &w_init;
   assign bus.payload_o          = r_payload;
   assign bus.addr_o             = r_addr;
   assign bus.header_fmt_o       = r_fmt;
   assign bus.header_type_o      = r_type;
   assign bus.header_tc_o        = r_tc;
   assign bus.header_requestID_o = r_rid;
   assign bus.header_completID_o = r_cid;
   assign bus.header_length_o    = r_len;

endmodule

// File: tb/tb_pcie_tx_tlp_arbiter.sv
// Directed scoreboard bench for the TX TLP arbiter.
module tb_pcie_tx_tlp_arbiter;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   pcie_tx_tlp_arbiter_if #(.N_REQ(3), .HDR_CRED_W(8), .DATA_CRED_W(12)) bus ();

   pcie_tx_tlp_arbiter #(.HDR_CRED_W(8), .DATA_CRED_W(12), .N_REQ(3)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   logic [127:0] s_pay  [3];
   logic [31:0]  s_addr [3];
   logic [2:0]   s_fmt  [3];
   logic [4:0]   s_type [3];
   logic [2:0]   s_tc   [3];
   logic [15:0]  s_rid  [3];
   logic [15:0]  s_cid  [3];
   logic [9:0]   s_len  [3];
   logic [2:0]   s_valid;

   assign bus.req_valid_i     = s_valid;
   assign bus.req_payload_i   = {s_pay[2], s_pay[1], s_pay[0]};
   assign bus.req_addr_i      = {s_addr[2], s_addr[1], s_addr[0]};
   assign bus.req_fmt_i       = {s_fmt[2], s_fmt[1], s_fmt[0]};
   assign bus.req_type_i      = {s_type[2], s_type[1], s_type[0]};
   assign bus.req_tc_i        = {s_tc[2], s_tc[1], s_tc[0]};
   assign bus.req_requestID_i = {s_rid[2], s_rid[1], s_rid[0]};
   assign bus.req_completID_i = {s_cid[2], s_cid[1], s_cid[0]};
   assign bus.req_length_i    = {s_len[2], s_len[1], s_len[0]};

   typedef struct {
      int           idx;
      logic [127:0] pay;
      logic [31:0]  addr;
      logic [52:0]  hdr;
   } exp_t;

   exp_t sb[$];
   int   total = 0;
   int   bad   = 0;
   int   cnt;

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [52:0] exp_hdr(input int i);
      return {s_fmt[i], s_type[i], s_tc[i], s_rid[i], s_cid[i], s_len[i]};
   endfunction

   function automatic logic [52:0] hdr_out();
      return {bus.header_fmt_o, bus.header_type_o, bus.header_tc_o,
              bus.header_requestID_o, bus.header_completID_o, bus.header_length_o};
   endfunction

   task automatic set_req(input int i, input logic [2:0] fmt, input logic [4:0] typ,
                          input logic [9:0] len, input logic [7:0] seed);
      s_fmt[i]  = fmt;
      s_type[i] = typ;
      s_len[i]  = len;
      s_tc[i]   = 3'(i);
      s_rid[i]  = {8'h10 + 8'(i), seed};
      s_cid[i]  = {seed, 8'hC0};
      s_addr[i] = {seed, 24'h001000} + 32'(i * 4);
      s_pay[i]  = {2{seed, 24'(i), seed ^ 8'hFF, 24'h5A5A5A}};
   endtask

   task automatic push_exp(input int i);
      exp_t e;
      e.idx  = i;
      e.pay  = s_pay[i];
      e.addr = s_addr[i];
      e.hdr  = exp_hdr(i);
      sb.push_back(e);
   endtask

   task automatic fc_update(input logic [1:0] cls, input logic [7:0] h, input logic [11:0] d);
      bus.fc_valid_i      = 1'b1;
      bus.fc_class_i      = cls;
      bus.fc_hdr_limit_i  = h;
      bus.fc_data_limit_i = d;
      step();
      bus.fc_valid_i      = 1'b0;
   endtask

   task automatic do_reset();
      rst_n           = 1'b0;
      s_valid         = '0;
      bus.tlp_ready_i = 1'b0;
      bus.fc_valid_i  = 1'b0;
      repeat (2) step();
      rst_n = 1'b1;
      step();
   endtask

   task automatic check_idle(input int n, input string tag);
      bit seen = 1'b0;
      repeat (n) begin
         @(negedge clk);
         if (bus.req_ready_o != 3'b000 || bus.tlp_valid_o) seen = 1'b1;
      end
      chk(tag, 128'(seen), 128'd0);
   endtask

   // Waits for a grant, checks it against the scoreboard head, holds, then handshakes
   task automatic grant_and_send(input int hold, input logic [2:0] drop);
      bit         found = 1'b0;
      exp_t       e;
      logic [2:0] oh;
      for (int c = 0; c < 40 && !found; c++) begin
         @(negedge clk);
         if (bus.req_ready_o != 3'b000) found = 1'b1;
      end
      chk("grant_seen", 128'(found), 128'd1);
      chk("sb_nonempty", 128'(sb.size() != 0), 128'd1);
      if (!found || sb.size() == 0) return;
      e  = sb.pop_front();
      oh = 3'b001 << e.idx;
      chk("ready_onehot", 128'(bus.req_ready_o), 128'(oh));
      @(negedge clk);
      chk("tlp_valid", 128'(bus.tlp_valid_o), 128'd1);
      chk("no_ready_in_send", 128'(bus.req_ready_o), 128'd0);
      chk("payload", bus.payload_o, e.pay);
      chk("addr", 128'(bus.addr_o), 128'(e.addr));
      chk("header", 128'(hdr_out()), 128'(e.hdr));
      s_valid = s_valid & ~drop;
      repeat (hold) begin
         @(negedge clk);
         chk("valid_hold", 128'(bus.tlp_valid_o), 128'd1);
         chk("header_hold", 128'(hdr_out()), 128'(e.hdr));
      end
      bus.tlp_ready_i = 1'b1;
      step();
      bus.tlp_ready_i = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
      $fatal(1, "watchdog expired");
   end

   initial begin
      for (int i = 0; i < 3; i++) set_req(i, 3'b000, 5'b00000, 10'd0, 8'h00);
      s_valid             = '0;
      bus.tlp_ready_i     = 1'b0;
      bus.fc_valid_i      = 1'b0;
      bus.fc_class_i      = 2'd0;
      bus.fc_hdr_limit_i  = '0;
      bus.fc_data_limit_i = '0;
      do_reset();

      // Reset values
      chk("rst_tlp_valid", 128'(bus.tlp_valid_o), 128'd0);
      chk("rst_ready", 128'(bus.req_ready_o), 128'd0);
      chk("rst_payload", bus.payload_o, 128'd0);
      chk("rst_header", 128'(hdr_out()), 128'd0);
      chk("rst_init_done", 128'(bus.fc_init_done_o), 128'd0);

      // No credits advertised: nothing is granted
      for (int i = 0; i < 3; i++) set_req(i, 3'b011, 5'b00000, 10'd4, 8'(8'h20 + i));
      s_valid = 3'b111;
      check_idle(20, "no_fc_no_grant");
      chk("no_fc_init_done", 128'(bus.fc_init_done_o), 128'd0);

      // Init all classes; round-robin 0,1,2,0
      s_valid = 3'b000;
      step();
      fc_update(2'd0, 8'd8, 12'd64);
      fc_update(2'd1, 8'd8, 12'd64);
      chk("init_partial", 128'(bus.fc_init_done_o), 128'd0);
      fc_update(2'd2, 8'd8, 12'd64);
      chk("init_done", 128'(bus.fc_init_done_o), 128'd1);
      s_valid = 3'b111;
      push_exp(0); push_exp(1); push_exp(2);
      grant_and_send(2, 3'b000);
      set_req(0, 3'b011, 5'b00000, 10'd4, 8'h2A);
      push_exp(0);
      grant_and_send(1, 3'b000);
      grant_and_send(0, 3'b000);
      grant_and_send(3, 3'b111);

      // P header limit of 1 blocks the second P request until raised
      do_reset();
      fc_update(2'd0, 8'd1, 12'd64);
      fc_update(2'd1, 8'd8, 12'd64);
      fc_update(2'd2, 8'd8, 12'd64);
      set_req(0, 3'b011, 5'b00000, 10'd4, 8'h31);
      s_valid = 3'b001;
      push_exp(0);
      grant_and_send(0, 3'b000);
      set_req(0, 3'b011, 5'b00000, 10'd4, 8'h32);
      check_idle(6, "p_hdr_blocked");
      push_exp(0);
      fc_update(2'd0, 8'd2, 12'd64);
      grant_and_send(0, 3'b001);

      // Grant and limit update to the same class in one cycle: both take effect
      set_req(1, 3'b000, 5'b00000, 10'd1, 8'h41);
      bus.fc_valid_i      = 1'b1;
      bus.fc_class_i      = 2'd1;
      bus.fc_hdr_limit_i  = 8'd1;
      bus.fc_data_limit_i = 12'd64;
      s_valid             = 3'b010;
      @(negedge clk);
      chk("simul_ready", 128'(bus.req_ready_o), 128'd2);
      step();
      bus.fc_valid_i = 1'b0;
      @(negedge clk);
      chk("simul_tlp_valid", 128'(bus.tlp_valid_o), 128'd1);
      chk("simul_header", 128'(hdr_out()), 128'(exp_hdr(1)));
      bus.tlp_ready_i = 1'b1;
      step();
      bus.tlp_ready_i = 1'b0;
      set_req(1, 3'b000, 5'b00000, 10'd1, 8'h42);
      check_idle(5, "np_blocked_after_simul");
      s_valid = 3'b000;

      // No head-of-line blocking; zero-length data and no-data costs
      do_reset();
      fc_update(2'd0, 8'd8, 12'd2);
      fc_update(2'd1, 8'd8, 12'd0);
      fc_update(2'd2, 8'd8, 12'd255);
      set_req(0, 3'b011, 5'b00000, 10'd12, 8'h51);
      set_req(1, 3'b000, 5'b00000, 10'd16, 8'h52);
      set_req(2, 3'b010, 5'b01010, 10'd0, 8'h53);
      s_valid = 3'b111;
      push_exp(1);
      grant_and_send(0, 3'b010);
      check_idle(5, "p_cpl_data_blocked");
      push_exp(0);
      fc_update(2'd0, 8'd8, 12'd3);
      grant_and_send(0, 3'b001);
      push_exp(2);
      fc_update(2'd2, 8'd8, 12'd256);
      grant_and_send(1, 3'b100);

      // Header credit wrap: 250 grants, then limit 2 gives a gap of 8
      do_reset();
      fc_update(2'd0, 8'd250, 12'd4095);
      set_req(0, 3'b011, 5'b00000, 10'd4, 8'h61);
      s_valid         = 3'b001;
      bus.tlp_ready_i = 1'b1;
      cnt = 0;
      repeat (600) begin
         @(negedge clk);
         if (bus.req_ready_o[0]) cnt++;
      end
      chk("grants_to_250", 128'(cnt), 128'd250);
      fc_update(2'd0, 8'd2, 12'd4095);
      cnt = 0;
      repeat (60) begin
         @(negedge clk);
         if (bus.req_ready_o[0]) cnt++;
      end
      chk("wrap_grants", 128'(cnt), 128'd8);
      s_valid         = 3'b000;
      bus.tlp_ready_i = 1'b0;
      step();

      // Class 3 ignored; reset mid-SEND aborts and clears credits
      do_reset();
      set_req(0, 3'b011, 5'b00000, 10'd4, 8'h71);
      s_valid = 3'b001;
      fc_update(2'd3, 8'd8, 12'd64);
      chk("class3_no_init", 128'(bus.fc_init_done_o), 128'd0);
      check_idle(4, "class3_ignored");
      fc_update(2'd1, 8'd8, 12'd64);
      fc_update(2'd2, 8'd8, 12'd64);
      fc_update(2'd0, 8'd8, 12'd64);
      @(negedge clk);
      chk("pre_rst_ready", 128'(bus.req_ready_o), 128'd1);
      @(negedge clk);
      chk("pre_rst_valid", 128'(bus.tlp_valid_o), 128'd1);
      chk("pre_rst_init_done", 128'(bus.fc_init_done_o), 128'd1);
      #1 rst_n = 1'b0;
      #1;
      chk("rst_mid_valid", 128'(bus.tlp_valid_o), 128'd0);
      chk("rst_mid_init_done", 128'(bus.fc_init_done_o), 128'd0);
      chk("rst_mid_payload", bus.payload_o, 128'd0);
      step();
      rst_n = 1'b1;
      check_idle(10, "no_grant_before_reinit");
      push_exp(0);
      fc_update(2'd0, 8'd8, 12'd64);
      grant_and_send(0, 3'b001);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/pcie_tx_tlp_arbiter.md
Name: pcie_tx_tlp_arbiter

Overview:
Shares the TX transaction-layer TLP build port between three requesters: posted (P), non-posted (NP) and completion (CPL).
Picks a requester by round-robin, gated by PCIe-style flow-control credits advertised by the link partner. Registers the winning request fields and presents them to the TX transaction layer under a valid/ready handshake.
Sits between the request sources and the TX transaction layer. The credit limit updates come from the DLLP path.

Parameters:
HDR_CRED_W, 8, width of header credit counters (modulo 2^8 arithmetic)
DATA_CRED_W, 12, width of data credit counters (modulo 2^12 arithmetic)
N_REQ, 3, number of requesters; fixed classes: 0=P, 1=NP, 2=CPL (only 3 supported)

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
req_valid_i  in  N_REQ  per-requester request valid
req_ready_o  out  N_REQ  per-requester accept; one-hot or zero
req_payload_i  in  N_REQ*128  payload per requester
req_addr_i  in  N_REQ*32  address per requester
req_fmt_i  in  N_REQ*3  header fmt per requester
req_type_i  in  N_REQ*5  header type per requester
req_tc_i  in  N_REQ*3  traffic class per requester
req_requestID_i  in  N_REQ*16  requester ID per requester
req_completID_i  in  N_REQ*16  completer ID per requester
req_length_i  in  N_REQ*10  length in DW per requester
fc_valid_i  in  1  credit-limit update strobe
fc_class_i  in  2  class of update: 0=P, 1=NP, 2=CPL, 3=ignored
fc_hdr_limit_i  in  HDR_CRED_W  new header credit limit
fc_data_limit_i  in  DATA_CRED_W  new data credit limit
payload_o, addr_o, header_fmt_o, header_type_o, header_tc_o, header_requestID_o, header_completID_o, header_length_o  out  128/32/3/5/3/16/16/10  registered fields of the granted TLP
tlp_valid_o  out  1  output TLP valid
tlp_ready_i  in  1  TX transaction layer accepts
fc_init_done_o  out  1  all three classes have received at least one update

Behaviour:
- Reset values:
  - all outputs 0;
  - consumed counters 0; limits 0; per-class init flags 0;
  - round-robin pointer = 0; state IDLE.
- Credit cost of a request:
  - header = 1;
  - data = ceil(length/4), computed as (length+3)>>2;
  - length 0 with fmt bit1 = 1 (with data) costs 256 data credits (1024 DW);
  - fmt bit1 = 0 costs 0 data credits.
- Eligibility of requester i: req_valid_i[i] AND init flag of its class AND (hdr_limit - hdr_consumed) mod 2^HDR_CRED_W >= 1 AND (data_limit - data_consumed) mod 2^DATA_CRED_W >= data cost.
- FSM IDLE:
  - if any requester is eligible, grant the first eligible index at or after the pointer, wrapping;
  - assert req_ready_o for that index for exactly 1 cycle;
  - capture its fields into the output registers;
  - add its cost to that class's consumed counters (wrapping);
  - pointer <= grant+1 mod N_REQ;
  - go to SEND.
- FSM SEND:
  - tlp_valid_o = 1; fields held stable;
  - on tlp_ready_i, go to IDLE;
  - no new grant is made in the same cycle, giving a throughput of one TLP per 2 cycles minimum.
- Latency: req_valid_i high in cycle N, with credits available → req_ready_o in cycle N (combinational from registered state) → tlp_valid_o in cycle N+1.
- Non-eligible requesters are skipped; there is no head-of-line blocking across classes. A starved requester keeps priority via the pointer once it becomes eligible.
- fc_valid_i:
  - loads the limit registers of the selected class and sets its init flag, taking effect the next cycle;
  - class 3 is ignored;
  - an update coinciding with a grant to the same class: the limit update and the consumed increment both apply.
- Wrap-around: all credit arithmetic is modular; no saturation. A credit gap of 2^HDR_CRED_W-1 is legal.
- req_valid_i dropping without ready is tolerated and no grant is made. Requesters must hold their fields stable while valid.
- Asynchronous reset mid-SEND aborts the TLP:
  - tlp_valid_o falls immediately;
  - credits are cleared and init flags are cleared, so re-init via fc_valid_i is required.

Decomposition:
- Shared package pcie_tx_pkg:
  - class enum (FC_P, FC_NP, FC_CPL);
  - fmt bit positions;
  - state enum (IDLE, SEND);
  - data-credit-cost function;
  - credit widths.
- One natural sub-module: pcie_fc_credit_gate, one instance per class. It holds the limit/consumed registers, the init flag, and the has-credit compare.

Test Plan:
- No fc updates, all req_valid_i=1 → req_ready_o stays 0 and tlp_valid_o stays 0 for 20 cycles; fc_init_done_o=0.
- Init all classes with hdr=8 and data=64; all three request MWr length=4 → grants in order 0,1,2,0; each TLP fields match its source; tlp_valid_o held until tlp_ready_i.
- P class: hdr_limit=1; two P requests length=4 → first granted; second blocked until an fc update with hdr_limit=2, then granted on the next IDLE cycle.
- P data_limit=2, request length=12 (cost 3) blocked while an NP request is granted → no head-of-line blocking; raise P data_limit to 3 → P granted.
- Consumed at 250 and limit wraps to 2 (gap 8) → 8 header-credit grants succeed and the 9th blocks.
- Assert rst_n low during SEND → tlp_valid_o=0 immediately; after release, no grant until re-init.
